synth_voice: RTL and testbench

SYNTH_VOICE -- requirements
Module: synth_voice

---
 rtl/synth_voice.sv | 134 +++++++++++++
 tb/tb_synth_voice.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/synth_voice.sv
// Single synthesizer voice: phase accumulator, five waveforms, and an attack/sustain/release envelope.
// Optional PWM LFO on the pulse threshold is enabled by defining SYNTH_VOICE_PWM_LFO_EN.
module synth_voice #(
  parameter int ACC_W = 28,
  parameter int INC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] increment,
  input  logic             sync,
  input  logic [2:0]       wave_sel,
  input  logic [15:0]      pulsewidth,
  input  logic             gate,
  input  logic             env_tick,
  input  logic [15:0]      attack_rate,
  input  logic [15:0]      release_rate,
  output logic [15:0]      out,
  output logic [15:0]      env_level,
  output logic [1:0]       env_state,
  output logic             active
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  env_state_t    state;
  logic [ACC_W:0] acc;
  logic [ACC_W:0] acc_next;
  logic [15:0]   lfsr;
  logic [15:0]   phase;
  logic [15:0]   tri_wave;
  logic [15:0]   eff_pw;
  logic [15:0]   wave;
  logic [31:0]   product;
  logic [16:0]   att_sum;

  always_comb begin
    acc_next = acc + {{(ACC_W + 1 - INC_W){1'b0}}, increment};
    phase    = acc[ACC_W-1 -: 16];
    tri_wave = acc[ACC_W-1] ? ~acc[ACC_W-2 -: 16] : acc[ACC_W-2 -: 16];
    att_sum  = {1'b0, env_level} + {1'b0, attack_rate};
  end

`ifdef SYNTH_VOICE_PWM_LFO_EN
  logic [23:0] lfo;
  logic [12:0] lfo_tri;
  logic [16:0] pw_sum;

  always_ff @(posedge clk) begin
    if (rst) lfo <= '0;
    else     lfo <= lfo + 24'd1;
  end

  // Triangle-shaped LFO offset added to the threshold, saturating instead of wrapping
  always_comb begin
    lfo_tri = lfo[23] ? ~lfo[22:10] : lfo[22:10];
    pw_sum  = {1'b0, pulsewidth} + {4'b0, lfo_tri};
    eff_pw  = pw_sum[16] ? 16'hFFFF : pw_sum[15:0];
  end
`else
  always_comb eff_pw = pulsewidth;
`endif

  always_comb begin
    case (wave_sel)
      3'd0:    wave = phase;
      3'd1:    wave = (phase < eff_pw) ? 16'hFFFF : 16'h0000;
      3'd2:    wave = tri_wave;
      3'd3:    wave = {16{acc[ACC_W]}};
      3'd4:    wave = lfsr;
      default: wave = 16'h0000;
    endcase
    product = wave * env_level;
  end

  // The noise register steps on each rising edge of the phase MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      lfsr <= 16'hACE1;
      out  <= 16'h0000;
    end else begin
      acc <= sync ? '0 : acc_next;
      if (!acc[ACC_W-1] && !sync && acc_next[ACC_W-1])
        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      out <= product[31:16];
    end
  end

  // Gate transitions take priority; a tick only steps the level in the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      env_level <= 16'h0000;
    end else begin
      case (state)
        IDLE: if (gate) state <= ATTACK;
        ATTACK:
          if (!gate) state <= RELEASE;
          else if (env_tick) begin
            if (att_sum >= 17'h0FFFF) begin
              env_level <= 16'hFFFF;
              state     <= SUSTAIN;
            end else begin
              env_level <= att_sum[15:0];
            end
          end
        SUSTAIN: begin
          env_level <= 16'hFFFF;
          if (!gate) state <= RELEASE;
        end
        RELEASE:
          if (gate) state <= ATTACK;
          else if (env_tick) begin
            if (release_rate >= env_level) begin
              env_level <= 16'h0000;
              state     <= IDLE;
            end else begin
              env_level <= env_level - release_rate;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end

  assign env_state = state;
  assign active    = (state != IDLE);

endmodule

// File: tb/tb_synth_voice.sv
// Self-checking bench for synth_voice: directed envelope/wave scenarios followed by randomized
// stimulus, all compared against an arithmetic reference model of the voice.
module tb_synth_voice;

  localparam int ACC_W = 28;
  localparam int INC_W = 18;
  localparam longint unsigned ACC_MOD = 64'd1 << (ACC_W + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [INC_W-1:0] increment;
  logic             sync;
  logic [2:0]       wave_sel;
  logic [15:0]      pulsewidth;
  logic             gate;
  logic             env_tick;
  logic [15:0]      attack_rate;
  logic [15:0]      release_rate;
  logic [15:0]      out;
  logic [15:0]      env_level;
  logic [1:0]       env_state;
  logic             active;

  int checks = 0;
  int passes = 0;

  longint unsigned m_acc;
  int m_lfsr;
  int m_env;
  int m_state;
  int m_out;
  int m_lfo;

  always #5 clk = ~clk;

  synth_voice #(.ACC_W(ACC_W), .INC_W(INC_W)) dut (
    .clk(clk), .rst(rst), .increment(increment), .sync(sync), .wave_sel(wave_sel),
    .pulsewidth(pulsewidth), .gate(gate), .env_tick(env_tick), .attack_rate(attack_rate),
    .release_rate(release_rate), .out(out), .env_level(env_level), .env_state(env_state),
    .active(active)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, observed, expected);
  endtask

  function automatic int bitsOf(input longint unsigned a, input int lo, input int n);
    return int'((a >> lo) & ((64'd1 << n) - 1));
  endfunction

  function automatic int lfsrNext(input int x);
    int y;
    y = x >> 1;
    if (x % 2 == 1) y = y ^ 'hB400;
    return y;
  endfunction

  function automatic int effPw();
    int t;
    int s;
    t = 0;
`ifdef SYNTH_VOICE_PWM_LFO_EN
    t = (m_lfo >> 10) % 8192;
    if ((m_lfo >> 23) % 2 == 1) t = 8191 - t;
`endif
    s = int'(pulsewidth) + t;
    return (s > 65535) ? 65535 : s;
  endfunction

  function automatic int waveNow();
    int p;
    int t;
    p = bitsOf(m_acc, ACC_W - 16, 16);
    case (wave_sel)
      3'd0: return p;
      3'd1: return (p < effPw()) ? 65535 : 0;
      3'd2: begin
        t = bitsOf(m_acc, ACC_W - 17, 16);
        return (bitsOf(m_acc, ACC_W - 1, 1) == 1) ? 65535 - t : t;
      end
      3'd3: return (bitsOf(m_acc, ACC_W, 1) == 1) ? 65535 : 0;
      3'd4: return m_lfsr;
      default: return 0;
    endcase
  endfunction

  task automatic modelReset();
    m_acc = 0; m_lfsr = 'hACE1; m_env = 0; m_state = 0; m_out = 0; m_lfo = 0;
  endtask

  // One clock of the voice, evaluated from the values present before the edge
  task automatic modelStep();
    int nxt_out;
    longint unsigned nxt_acc;
    if (rst) begin
      modelReset();
    end else begin
      nxt_out = int'((longint'(waveNow()) * longint'(m_env)) >> 16);
      nxt_acc = sync ? 64'd0 : (m_acc + longint'(increment)) % ACC_MOD;
      if (bitsOf(m_acc, ACC_W - 1, 1) == 0 && bitsOf(nxt_acc, ACC_W - 1, 1) == 1)
        m_lfsr = lfsrNext(m_lfsr);
      case (m_state)
        0: if (gate) m_state = 1;
        1: if (!gate) m_state = 3;
           else if (env_tick) begin
             m_env = m_env + int'(attack_rate);
             if (m_env >= 65535) begin m_env = 65535; m_state = 2; end
           end
        2: if (!gate) m_state = 3;
        default: if (gate) m_state = 1;
           else if (env_tick) begin
             m_env = m_env - int'(release_rate);
             if (m_env <= 0) begin m_env = 0; m_state = 0; end
           end
      endcase
      m_acc = nxt_acc;
      m_out = nxt_out;
      m_lfo = (m_lfo + 1) % (1 << 24);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput("out", out, m_out);
      checkOutput("env_level", env_level, m_env);
      checkOutput("env_state", env_state, m_state);
      checkOutput("active", active, m_state != 0);
    end
  endtask

  initial begin
    logic [15:0] exp_lvl [4];
    exp_lvl = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
    modelReset();
    rst = 1'b1; sync = 1'b0; increment = '0; wave_sel = 3'd0; pulsewidth = 16'h0;
    gate = 1'b0; env_tick = 1'b0; attack_rate = 16'h0; release_rate = 16'h0;
    applyStimulus(2);
    checkOutput("reset_out", out, 0);
    checkOutput("reset_state", env_state, 0);

    // Saw at one phase step per clock with an instant attack
    rst = 1'b0; increment = INC_W'(4096); gate = 1'b1; attack_rate = 16'hFFFF; env_tick = 1'b1;
    applyStimulus(2);
    checkOutput("instant_attack_state", env_state, 2);
    env_tick = 1'b0;
    applyStimulus(20);

    // Release, retrigger from a partial level, then release to idle
    gate = 1'b0; release_rate = 16'h8000; env_tick = 1'b1;
    applyStimulus(2);
    checkOutput("release_half", env_level, 16'h7FFF);
    gate = 1'b1; env_tick = 1'b0;
    applyStimulus(1);
    checkOutput("retrigger_state", env_state, 1);
    checkOutput("retrigger_level", env_level, 16'h7FFF);
    gate = 1'b0; env_tick = 1'b1;
    applyStimulus(2);
    checkOutput("release_zero", env_level, 0);
    checkOutput("release_idle", active, 0);

    // Stepped attack with saturation on the fourth tick
    gate = 1'b1; attack_rate = 16'h4000;
    applyStimulus(1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1);
      checkOutput("attack_step", env_level, exp_lvl[k]);
    end
    checkOutput("attack_sustain", env_state, 2);

    // Pulse at half width, then zero width
    env_tick = 1'b0; wave_sel = 3'd1; pulsewidth = 16'h8000; increment = INC_W'(18'h25000);
    applyStimulus(300);
    pulsewidth = 16'h0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1);
`ifndef SYNTH_VOICE_PWM_LFO_EN
      checkOutput("pulse_zero_width", out, 0);
`endif
    end
`ifdef SYNTH_VOICE_PWM_LFO_EN
    pulsewidth = 16'hF000;
    applyStimulus(300);
`endif

    // Hard sync, then reset during attack
    wave_sel = 3'd0; sync = 1'b1;
    applyStimulus(1);
    sync = 1'b0;
    applyStimulus(1);
    checkOutput("sync_out", out, 0);
    gate = 1'b0;
    applyStimulus(1);
    gate = 1'b1;
    applyStimulus(1);
    rst = 1'b1; env_tick = 1'b1;
    applyStimulus(1);
    checkOutput("rst_attack_state", env_state, 0);
    rst = 1'b0; wave_sel = 3'd4; increment = INC_W'(4096); attack_rate = 16'hFFFF;
    applyStimulus(3);
    checkOutput("lfsr_seed", out, 16'hACE0);

    // Noise and triangle at high rates before going fully random
    increment = INC_W'(18'h3FFFF); env_tick = 1'b0;
    applyStimulus(200);
    wave_sel = 3'd2;
    applyStimulus(100);

    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        increment    = INC_W'($urandom);
        wave_sel     = 3'($urandom);
        pulsewidth   = 16'($urandom);
        attack_rate  = ($urandom % 5 == 0) ? 16'h0 : 16'($urandom_range(1, 16'h6000));
        release_rate = ($urandom % 5 == 0) ? 16'h0 : 16'($urandom_range(1, 16'h6000));
      end
      gate     = ($urandom % 40 == 0) ? ~gate : gate;
      env_tick = ($urandom % 3 == 0);
      sync     = ($urandom % 200 == 0);
      rst      = ($urandom % 700 == 0);
      applyStimulus(1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
